// File: rtl/sr_piso_framer.sv
// Parallel-in serial-out framer: serializes 8-bit words into contiguous frames,
// with an optional trailing even-parity bit and a one-word holding buffer.
module sr_piso_framer #(
    parameter int MSB_FIRST = 0,
    parameter int PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:1] d,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_first,
    output logic       sout_last,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    localparam bit MSB = (MSB_FIRST != 0);
    localparam bit PAR = (PARITY_EN != 0);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] buf_q, buf_d;
    logic       full_q, full_d;
    logic       par_q, par_d;
    logic       sout_q, sout_d;
    logic       vld_q, vld_d;
    logic       first_q, first_d;
    logic       last_q, last_d;

    logic       accept;
    logic       frame_final;
    logic       load_en;
    logic [7:0] load_word;

    function automatic logic first_bit(input logic [7:0] w);
        return MSB ? w[7] : w[0];
    endfunction

    function automatic logic [7:0] rest_bits(input logic [7:0] w);
        return MSB ? {w[6:0], 1'b0} : {1'b0, w[7:1]};
    endfunction

    assign in_ready    = reset & ~full_q;
    assign accept      = in_valid & in_ready;
    // The edge that ends the last bit of the current frame.
    assign frame_final = (state_q == PARITY) ||
                         ((state_q == SHIFT) && (cnt_q == 4'd7) && !PAR);

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        full_d    = full_q;
        par_d     = par_q;
        sout_d    = 1'b0;
        vld_d     = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        load_en   = 1'b0;
        load_word = d;

        case (state_q)
            IDLE: begin
                if (accept) load_en = 1'b1;
            end
            SHIFT: begin
                if (cnt_q != 4'd7) begin
                    sout_d = first_bit(sr_q);
                    sr_d   = rest_bits(sr_q);
                    cnt_d  = cnt_q + 4'd1;
                    vld_d  = 1'b1;
                    last_d = (cnt_q == 4'd6) && !PAR;
                end else if (PAR) begin
                    state_d = PARITY;
                    sout_d  = par_q;
                    vld_d   = 1'b1;
                    last_d  = 1'b1;
                end
            end
            default: ;
        endcase

        // Buffered word wins over a word arriving on the same edge.
        if (frame_final) begin
            if (full_q) begin
                load_en   = 1'b1;
                load_word = buf_q;
                full_d    = 1'b0;
            end else if (accept) begin
                load_en = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (accept && (state_q != IDLE)) begin
            buf_d  = d;
            full_d = 1'b1;
        end

        // Bit 1 goes straight to the output flop; the rest stay in sr.
        if (load_en) begin
            state_d = SHIFT;
            sr_d    = rest_bits(load_word);
            cnt_d   = 4'd0;
            par_d   = ^load_word;
            sout_d  = first_bit(load_word);
            vld_d   = 1'b1;
            first_d = 1'b1;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= 8'h00;
            cnt_q   <= 4'd0;
            buf_q   <= 8'h00;
            full_q  <= 1'b0;
            par_q   <= 1'b0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            par_q   <= par_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = vld_q;
    assign sout_first = first_q;
    assign sout_last  = last_q;
    assign busy       = (state_q != IDLE) | full_q;

endmodule
